sprite_motion_2d: RTL and testbench

//  Frame-rate 2-D motion controller for a sprite (player, enemy, projectile). Integrates a

---
 rtl/sprite_motion_pkg.sv | 28 ++
 rtl/axis_integrator.sv | 83 ++++++++
 rtl/sprite_motion_2d.sv | 175 +++++++++++++++++
 tb/tb_sprite_motion_2d.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_motion_pkg.sv
// Shared types and constants for the 2-D sprite motion controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_motion_pkg;

    typedef enum logic [1:0] {
        CLAMP  = 2'd0,
        WRAP   = 2'd1,
        BOUNCE = 2'd2
    } edge_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        RECOIL = 2'd2,
        PAUSED = 2'd3
    } motion_state_t;

    // Default number of fixed-point fraction bits (1/64 pixel).
    localparam int FP_SHIFT_DEF = 6;

    // Bit positions inside HitEdgeCode.
    localparam int HIT_LEFT   = 0;
    localparam int HIT_TOP    = 1;
    localparam int HIT_RIGHT  = 2;
    localparam int HIT_BOTTOM = 3;

endpackage

// File: rtl/axis_integrator.sv
// One motion axis: velocity ramp/friction, position integrate and edge policy.
// Latency: position and velocity registered on the enabled edge, visible next cycle.
// Backpressure: none; updates only on cycles where enable is high, holds otherwise.
module axis_integrator
    import sprite_motion_pkg::*;
#(
    parameter int         INIT_POS  = 280,
    parameter int         FP_SHIFT  = FP_SHIFT_DEF,
    parameter int         MAX_SPEED = 640,
    parameter int         ACCEL     = 16,
    parameter int         FRICTION  = 16,
    parameter edge_mode_t EDGE_MODE = CLAMP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               key_pos,
    input  logic               key_neg,
    input  logic               negate,
    input  logic signed [31:0] min,
    input  logic signed [31:0] max,
    output logic signed [31:0] pos,
    output logic signed [31:0] vel,
    output logic signed [31:0] vel_next
);

    localparam int INIT_FP = INIT_POS * (2 ** FP_SHIFT);

    logic signed [31:0] v_ramp;
    logic signed [31:0] p_sum;
    logic signed [31:0] p_new;
    logic signed [31:0] v_new;

    // Next velocity (negate / ramp / friction), then next position with the edge policy.
    always_comb begin
        v_ramp = vel;
        if (negate) begin
            v_ramp = -vel;
        end else if (key_pos && !key_neg) begin
            v_ramp = (vel > MAX_SPEED - ACCEL) ? MAX_SPEED : vel + ACCEL;
        end else if (key_neg && !key_pos) begin
            v_ramp = (vel < ACCEL - MAX_SPEED) ? -MAX_SPEED : vel - ACCEL;
        end else if (vel > FRICTION) begin
            v_ramp = vel - FRICTION;
        end else if (vel < -FRICTION) begin
            v_ramp = vel + FRICTION;
        end else begin
            v_ramp = '0;
        end

        p_sum = pos + v_ramp;
        p_new = p_sum;
        v_new = v_ramp;
        // Landing exactly on a bound is legal; only strictly outside triggers the policy.
        if (p_sum > max) begin
            case (EDGE_MODE)
                WRAP:    p_new = min;
                BOUNCE:  begin p_new = max; v_new = -v_ramp; end
                default: begin p_new = max; v_new = '0;      end
            endcase
        end else if (p_sum < min) begin
            case (EDGE_MODE)
                WRAP:    p_new = max;
                BOUNCE:  begin p_new = min; v_new = -v_ramp; end
                default: begin p_new = min; v_new = '0;      end
            endcase
        end
    end

    assign vel_next = v_new;

    // Commit the frame update; otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= INIT_FP;
            vel <= '0;
        end else if (enable) begin
            pos <= p_new;
            vel <= v_new;
        end
    end

endmodule

// File: rtl/sprite_motion_2d.sv
// Frame-rate 2-D sprite mover: per-axis integrators plus motion FSM, collision latch, recoil.
// Latency: all state updates on the startOfFrame edge, outputs visible the next cycle.
// Backpressure: none; pause freezes everything, a collision stays latched until applied.
module sprite_motion_2d
    import sprite_motion_pkg::*;
#(
    parameter int         INITIAL_X     = 280,
    parameter int         INITIAL_Y     = 185,
    parameter int         FP_SHIFT      = FP_SHIFT_DEF,
    parameter int         MAX_SPEED     = 640,
    parameter int         ACCEL         = 16,
    parameter int         FRICTION      = 16,
    parameter int         X_MIN         = 10,
    parameter int         X_MAX         = 560,
    parameter int         Y_MIN         = 0,
    parameter int         Y_MAX         = 440,
    parameter edge_mode_t EDGE_MODE     = CLAMP,
    parameter int         RECOIL_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               moveLeft,
    input  logic               moveRight,
    input  logic               moveUp,
    input  logic               moveDown,
    input  logic               pause,
    input  logic               collision,
    input  logic [3:0]         HitEdgeCode,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic signed [15:0] speedX,
    output logic signed [15:0] speedY,
    output logic               moving,
    output logic [1:0]         state
);

    localparam int          SCALE      = 2 ** FP_SHIFT;
    localparam logic [7:0]  RECOIL_CNT = 8'(RECOIL_FRAMES);

    motion_state_t      state_q, state_d;
    motion_state_t      prev_q, prev_d;
    motion_state_t      base_state;
    logic [7:0]         cnt_q, cnt_d;
    logic               coll_q, negx_q, negy_q;
    logic               coll_now, negx_now, negy_now;
    logic               hit_x, hit_y;
    logic               frame_en, keys_blocked, any_key, any_vel;
    logic signed [31:0] pos_x, pos_y, vel_x, vel_y, vnx, vny;

    assign frame_en = startOfFrame & ~pause;

    // A code of zero means "side unknown": treat it as a hit on both axes.
    assign hit_x = HitEdgeCode[HIT_LEFT] | HitEdgeCode[HIT_RIGHT] | (HitEdgeCode == 4'd0);
    assign hit_y = HitEdgeCode[HIT_TOP] | HitEdgeCode[HIT_BOTTOM] | (HitEdgeCode == 4'd0);

    // Include a collision arriving on the frame cycle itself.
    assign coll_now = coll_q | collision;
    assign negx_now = negx_q | (collision & hit_x);
    assign negy_now = negy_q | (collision & hit_y);

    // While paused, the FSM logically continues from the state saved at pause entry.
    assign base_state   = (state_q == PAUSED) ? prev_q : state_q;
    assign keys_blocked = coll_now | (base_state == RECOIL);
    assign any_key      = (moveLeft ^ moveRight) | (moveUp ^ moveDown);
    assign any_vel      = (vnx != 32'sd0) | (vny != 32'sd0);

    axis_integrator #(
        .INIT_POS (INITIAL_X), .FP_SHIFT(FP_SHIFT), .MAX_SPEED(MAX_SPEED),
        .ACCEL    (ACCEL),     .FRICTION(FRICTION), .EDGE_MODE(EDGE_MODE)
    ) u_axis_x (
        .clk     (clk),
        .reset   (reset),
        .enable  (frame_en),
        .key_pos (moveRight & ~keys_blocked),
        .key_neg (moveLeft & ~keys_blocked),
        .negate  (negx_now),
        .min     (32'(X_MIN * SCALE)),
        .max     (32'(X_MAX * SCALE)),
        .pos     (pos_x),
        .vel     (vel_x),
        .vel_next(vnx)
    );

    axis_integrator #(
        .INIT_POS (INITIAL_Y), .FP_SHIFT(FP_SHIFT), .MAX_SPEED(MAX_SPEED),
        .ACCEL    (ACCEL),     .FRICTION(FRICTION), .EDGE_MODE(EDGE_MODE)
    ) u_axis_y (
        .clk     (clk),
        .reset   (reset),
        .enable  (frame_en),
        .key_pos (moveDown & ~keys_blocked),
        .key_neg (moveUp & ~keys_blocked),
        .negate  (negy_now),
        .min     (32'(Y_MIN * SCALE)),
        .max     (32'(Y_MAX * SCALE)),
        .pos     (pos_y),
        .vel     (vel_y),
        .vel_next(vny)
    );

    // Collision latch: set on any cycle, consumed by the next unpaused frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_q <= 1'b0;
            negx_q <= 1'b0;
            negy_q <= 1'b0;
        end else if (frame_en) begin
            coll_q <= 1'b0;
            negx_q <= 1'b0;
            negy_q <= 1'b0;
        end else if (collision) begin
            coll_q <= 1'b1;
            negx_q <= negx_now;
            negy_q <= negy_now;
        end
    end

    // FSM state, saved pre-pause state and recoil counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prev_q  <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: pause wins, then collision, then recoil countdown, then idle/moving.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        if (pause) begin
            if (state_q != PAUSED) begin
                prev_d  = state_q;
                state_d = PAUSED;
            end
        end else begin
            state_d = base_state;
            if (startOfFrame) begin
                if (coll_now) begin
                    state_d = RECOIL;
                    cnt_d   = RECOIL_CNT;
                end else if (base_state == RECOIL) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = '0;
                        state_d = any_vel ? MOVING : IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    state_d = (any_key | any_vel) ? MOVING : IDLE;
                end
            end
        end
    end

    assign topLeftX = pos_x[FP_SHIFT +: 11];
    assign topLeftY = pos_y[FP_SHIFT +: 11];
    assign speedX   = vel_x[15:0];
    assign speedY   = vel_y[15:0];
    assign moving   = (state_q == MOVING);
    assign state    = state_q;

    // Fraction bits and high bits intentionally not exported.
    logic unused_bits;
    assign unused_bits = ^{pos_x[31:FP_SHIFT+11], pos_x[FP_SHIFT-1:0],
                           pos_y[31:FP_SHIFT+11], pos_y[FP_SHIFT-1:0],
                           vel_x[31:16], vel_y[31:16]};

endmodule

// File: tb/tb_sprite_motion_2d.sv
// Bench for sprite_motion_2d: four configurations driven in parallel against a reference model.
// Latency: outputs compared every falling edge.
// Backpressure: n/a.
module tb_sprite_motion_2d;
    import sprite_motion_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       moveLeft = 1'b0, moveRight = 1'b0, moveUp = 1'b0, moveDown = 1'b0;
    logic       pause = 1'b0, collision = 1'b0;
    logic [3:0] HitEdgeCode = 4'd0;

    logic signed [10:0] tlx [4];
    logic signed [10:0] tly [4];
    logic signed [15:0] spx [4];
    logic signed [15:0] spy [4];
    logic               mv  [4];
    logic [1:0]         stt [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0: default parameters. Instances 1..3: start at X=555 with ACCEL=640,
    // edge mode CLAMP, BOUNCE, WRAP respectively.
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            localparam edge_mode_t EM = (g == 2) ? BOUNCE : ((g == 3) ? WRAP : CLAMP);
            localparam int IX = (g == 0) ? 280 : 555;
            localparam int AC = (g == 0) ? 16 : 640;
            sprite_motion_2d #(.INITIAL_X(IX), .ACCEL(AC), .EDGE_MODE(EM)) u_dut (
                .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
                .moveLeft(moveLeft), .moveRight(moveRight), .moveUp(moveUp), .moveDown(moveDown),
                .pause(pause), .collision(collision), .HitEdgeCode(HitEdgeCode),
                .topLeftX(tlx[g]), .topLeftY(tly[g]), .speedX(spx[g]), .speedY(spy[g]),
                .moving(mv[g]), .state(stt[g])
            );
        end
    endgenerate

    // ---------------- reference model (mode: 0 clamp, 1 wrap, 2 bounce) ----------------
    localparam int M_INITX [4] = '{280, 555, 555, 555};
    localparam int M_ACC   [4] = '{16, 640, 640, 640};
    localparam int M_MODE  [4] = '{0, 0, 2, 1};

    int px [4], py [4], vx [4], vy [4], cnt [4], st [4];
    bit paused [4], cl [4], nx [4], ny [4];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            px[i] = M_INITX[i] * 64; py[i] = 185 * 64;
            vx[i] = 0; vy[i] = 0; cnt[i] = 0; st[i] = 0;
            paused[i] = 0; cl[i] = 0; nx[i] = 0; ny[i] = 0;
        end
    endtask

    task automatic axis_step(input int p_in, input int v_in, input int dir, input bit neg,
                             input int lo, input int hi, input int acc, input int md,
                             output int p_out, output int v_out);
        int v;
        int p;
        v = v_in;
        if (neg) v = -v;
        else if (dir != 0) begin
            v = v + dir * acc;
            if (v > 640) v = 640;
            if (v < -640) v = -640;
        end else if (v > 16) v = v - 16;
        else if (v < -16) v = v + 16;
        else v = 0;
        p = p_in + v;
        if (p > hi * 64) begin
            if (md == 1) p = lo * 64;
            else begin p = hi * 64; v = (md == 2) ? -v : 0; end
        end else if (p < lo * 64) begin
            if (md == 1) p = hi * 64;
            else begin p = lo * 64; v = (md == 2) ? -v : 0; end
        end
        p_out = p;
        v_out = v;
    endtask

    task automatic model_step(input int i);
        int dx, dy;
        bit blocked;
        if (collision) begin
            cl[i] = 1;
            if (HitEdgeCode[0] || HitEdgeCode[2] || HitEdgeCode == 4'd0) nx[i] = 1;
            if (HitEdgeCode[1] || HitEdgeCode[3] || HitEdgeCode == 4'd0) ny[i] = 1;
        end
        if (pause) begin
            paused[i] = 1;
            return;
        end
        paused[i] = 0;
        if (!startOfFrame) return;
        blocked = cl[i] || (st[i] == 2);
        dx = blocked ? 0 : (int'(moveRight) - int'(moveLeft));
        dy = blocked ? 0 : (int'(moveDown) - int'(moveUp));
        axis_step(px[i], vx[i], dx, nx[i], 10, 560, M_ACC[i], M_MODE[i], px[i], vx[i]);
        axis_step(py[i], vy[i], dy, ny[i], 0, 440, M_ACC[i], M_MODE[i], py[i], vy[i]);
        if (cl[i]) begin
            st[i] = 2; cnt[i] = 4;
        end else if (st[i] == 2) begin
            cnt[i] = cnt[i] - 1;
            if (cnt[i] <= 0) begin
                cnt[i] = 0;
                st[i] = (vx[i] != 0 || vy[i] != 0) ? 1 : 0;
            end
        end else begin
            st[i] = (dx != 0 || dy != 0 || vx[i] != 0 || vy[i] != 0) ? 1 : 0;
        end
        cl[i] = 0; nx[i] = 0; ny[i] = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else for (int i = 0; i < 4; i++) model_step(i);
    end

    // Every-cycle compare of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dut%0d.topLeftX", i), int'(tlx[i]), px[i] >>> 6);
            chk($sformatf("dut%0d.topLeftY", i), int'(tly[i]), py[i] >>> 6);
            chk($sformatf("dut%0d.speedX", i), int'(spx[i]), vx[i]);
            chk($sformatf("dut%0d.speedY", i), int'(spy[i]), vy[i]);
            chk($sformatf("dut%0d.state", i), int'(stt[i]), paused[i] ? 3 : st[i]);
            chk($sformatf("dut%0d.moving", i), int'(mv[i]), (!paused[i] && st[i] == 1) ? 1 : 0);
        end
    end

    // ---------------- directed stimulus with hand-computed literals ----------------
    task automatic frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    task automatic hit(input logic [3:0] code);
        collision = 1'b1;
        HitEdgeCode = code;
        @(negedge clk);
        collision = 1'b0;
        HitEdgeCode = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst.X", int'(tlx[0]), 280);
        chk("rst.Y", int'(tly[0]), 185);
        chk("rst.speedX", int'(spx[0]), 0);
        chk("rst.state", int'(stt[0]), 0);
        chk("rst.X555", int'(tlx[1]), 555);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Edge policies: one frame of moveRight at 640 from X=555.
        moveRight = 1'b1;
        frame();
        chk("clamp.X", int'(tlx[1]), 560);
        chk("clamp.speedX", int'(spx[1]), 0);
        chk("bounce.X", int'(tlx[2]), 560);
        chk("bounce.speedX", int'(spx[2]), -640);
        chk("wrap.X", int'(tlx[3]), 10);
        chk("wrap.speedX", int'(spx[3]), 640);
        moveRight = 1'b0;
        frame();
        chk("clamp.state_idle", int'(stt[1]), 0);
        chk("bounce.speedX_f2", int'(spx[2]), -624);
        chk("bounce.X_f2", int'(tlx[2]), 550);

        // Acceleration ramp.
        do_reset();
        moveRight = 1'b1;
        frame(); chk("ramp.speedX_f1", int'(spx[0]), 16);
        frame(); chk("ramp.speedX_f2", int'(spx[0]), 32);
        frame(); chk("ramp.speedX_f3", int'(spx[0]), 48);
        chk("ramp.X_f3", int'(tlx[0]), 281);
        chk("ramp.Y_f3", int'(tly[0]), 185);

        // Reach full speed, then collide on the right side.
        for (int f = 0; f < 37; f++) frame();
        chk("full.speedX", int'(spx[0]), 640);
        hit(4'b0100);
        frame();
        chk("recoil.speedX", int'(spx[0]), -640);
        chk("recoil.state", int'(stt[0]), 2);
        frame(); chk("recoil.speedX_1", int'(spx[0]), -624);
        frame(); chk("recoil.speedX_2", int'(spx[0]), -608);
        frame(); chk("recoil.speedX_3", int'(spx[0]), -592);
        chk("recoil.state_3", int'(stt[0]), 2);
        frame(); chk("recoil.speedX_4", int'(spx[0]), -576);
        chk("recoil.exit_state", int'(stt[0]), 1);
        frame(); chk("post_recoil.speedX", int'(spx[0]), -560);

        // Pause freezes everything across frames.
        do_reset();
        frame(); frame();
        chk("prepause.speedX", int'(spx[0]), 32);
        pause = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame();
            chk("pause.speedX", int'(spx[0]), 32);
            chk("pause.X", int'(tlx[0]), 280);
            chk("pause.state", int'(stt[0]), 3);
        end
        pause = 1'b0;
        @(negedge clk);
        frame();
        chk("resume.speedX", int'(spx[0]), 48);
        chk("resume.X", int'(tlx[0]), 281);
        chk("resume.state", int'(stt[0]), 1);
        hit(4'b0000);
        frame();
        chk("hit0.speedX", int'(spx[0]), -48);
        chk("hit0.speedY", int'(spy[0]), 0);
        chk("hit0.state", int'(stt[0]), 2);
        frame();
        chk("hit0.speedX_f2", int'(spx[0]), -32);
        // Asynchronous reset in the middle of recoil, between clock edges.
        #2 reset = 1'b1;
        #1;
        chk("midrst.X", int'(tlx[0]), 280);
        chk("midrst.Y", int'(tly[0]), 185);
        chk("midrst.speedX", int'(spx[0]), 0);
        chk("midrst.state", int'(stt[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        moveRight = 1'b0;
        @(negedge clk);

        // Collision during pause stays latched; collision on a frame cycle re-triggers recoil.
        moveDown = 1'b1;
        frame(); frame();
        chk("down.speedY", int'(spy[0]), 32);
        pause = 1'b1;
        @(negedge clk);
        hit(4'b1000);
        frame();
        chk("pausehit.speedY", int'(spy[0]), 32);
        pause = 1'b0;
        @(negedge clk);
        frame();
        chk("latched.speedY", int'(spy[0]), -32);
        chk("latched.state", int'(stt[0]), 2);
        collision = 1'b1;
        HitEdgeCode = 4'b1000;
        startOfFrame = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        HitEdgeCode = 4'd0;
        startOfFrame = 1'b0;
        @(negedge clk);
        chk("samecycle.speedY", int'(spy[0]), 32);
        chk("samecycle.state", int'(stt[0]), 2);
        moveDown = 1'b0;
        for (int f = 0; f < 4; f++) frame();
        chk("settle.speedY", int'(spy[0]), 0);
        chk("settle.state", int'(stt[0]), 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
